// File: rtl/counter_sequencer_if.sv
// Control/status and counter-side signals between the register logic, the sequencer and the counter board.
interface counter_sequencer_if #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned PRESC_W = 8
) ();

  logic               start_i;
  logic               stop_i;
  logic               pause_i;
  logic               periodic_i;
  logic [PRESC_W-1:0] prescale_i;
  logic [CNT_W-1:0]   target_i;
  logic [CNT_W-1:0]   counter_value_i;
  logic               counter_enable_o;
  logic               counter_rst_n_o;
  logic               busy_o;
  logic               done_o;
  logic               err_o;

  // Register/control side plus counter board
  modport master (
    output start_i, stop_i, pause_i, periodic_i, prescale_i, target_i, counter_value_i,
    input  counter_enable_o, counter_rst_n_o, busy_o, done_o, err_o
  );

  // Sequencer side
  modport slave (
    input  start_i, stop_i, pause_i, periodic_i, prescale_i, target_i, counter_value_i,
    output counter_enable_o, counter_rst_n_o, busy_o, done_o, err_o
  );

endinterface

// File: rtl/counter_sequencer.sv
// Sequences an enable-gated counter: prescaled enable pulses, synchronous clear, tick counting and shadow check.
module counter_sequencer #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  counter_sequencer_if.slave bus
);

  // Tick counter is one bit wider so a target of 0 can mean 2^CNT_W
  localparam int unsigned TICK_W = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PRESC_W-1:0]  pcnt_q, pcnt_d;
  logic [TICK_W-1:0]   target_q, target_d;
  logic [TICK_W-1:0]   ticks_q, ticks_d;
  logic                periodic_q, periodic_d;
  logic [CNT_W-1:0]    shadow_q, shadow_d;
  logic                enable_q, enable_d;
  logic                rst_n_q, rst_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                complete_c;

  // Run is finished once the last tick has been issued (final pulse is on the enable this cycle)
  assign complete_c = (state_q == RUN) && (ticks_q == target_q);

  // State, datapath and registered outputs
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      pcnt_q     <= '0;
      target_q   <= '0;
      ticks_q    <= '0;
      periodic_q <= 1'b0;
      shadow_q   <= '0;
      enable_q   <= 1'b0;
      rst_n_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      target_q   <= target_d;
      ticks_q    <= ticks_d;
      periodic_q <= periodic_d;
      shadow_q   <= shadow_d;
      enable_q   <= enable_d;
      rst_n_q    <= rst_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state selection; stop wins over completion
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start_i) state_d = CLEAR;
      CLEAR:   state_d = bus.stop_i ? IDLE : RUN;
      RUN: begin
        if (bus.stop_i)      state_d = IDLE;
        else if (complete_c) state_d = periodic_q ? CLEAR : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and next output values; outputs are derived so they line up with the next state
  always_comb begin
    presc_d    = presc_q;
    pcnt_d     = pcnt_q;
    target_d   = target_q;
    ticks_d    = ticks_q;
    periodic_d = periodic_q;
    shadow_d   = shadow_q;
    enable_d   = 1'b0;
    rst_n_d    = (state_d != CLEAR);
    busy_d     = (state_d != IDLE);
    done_d     = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          presc_d    = bus.prescale_i;
          target_d   = (bus.target_i == '0) ? {1'b1, {CNT_W{1'b0}}} : TICK_W'(bus.target_i);
          periodic_d = bus.periodic_i;
          err_d      = 1'b0;
        end
      end
      CLEAR: begin
        shadow_d = '0;
        ticks_d  = '0;
        pcnt_d   = presc_q;
      end
      RUN: begin
        shadow_d = shadow_q + CNT_W'(enable_q);
        if (bus.counter_value_i != shadow_q) err_d = 1'b1;
        if (!bus.stop_i) begin
          if (complete_c) begin
            done_d = 1'b1;
          end else if (!bus.pause_i) begin
            if (pcnt_q == '0) begin
              if (ticks_q < target_q) begin
                enable_d = 1'b1;
                pcnt_d   = presc_q;
                ticks_d  = ticks_q + TICK_W'(1);
              end
            end else begin
              pcnt_d = pcnt_q - PRESC_W'(1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.counter_enable_o = enable_q;
  assign bus.counter_rst_n_o  = rst_n_q;
  assign bus.busy_o           = busy_q;
  assign bus.done_o           = done_q;
  assign bus.err_o            = err_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench: stimulus pushes expected enable/done events, a monitor pops and compares them.
module tb_counter_sequencer;

  typedef struct {
    int         cyc;
    logic [3:0] val;
    logic       err;
  } done_exp_t;

  logic       clk;
  logic       rst_n;
  logic       inject;
  logic [3:0] cnt;
  int         cyc;
  int         n_cmp;
  int         n_err;
  int         en_q[$];
  done_exp_t  done_q[$];

  counter_sequencer_if #(.CNT_W(4), .PRESC_W(8)) bus ();

  counter_sequencer #(.CNT_W(4), .PRESC_W(8)) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Counter board: synchronous clear, enable-gated increment
  initial cnt = 4'd0;
  always @(posedge clk) begin
    if (!bus.counter_rst_n_o) cnt <= 4'd0;
    else if (bus.counter_enable_o) cnt <= cnt + 4'd1;
  end

  assign bus.counter_value_i = inject ? cnt + 4'd1 : cnt;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every enable pulse and done pulse must match the next queued expectation
  always @(negedge clk) begin : monitor
    int        e;
    done_exp_t d;
    if (bus.counter_enable_o === 1'b1) begin
      if (en_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_enable: got pulse expected none (cycle %0d)", cyc);
      end else begin
        e = en_q.pop_front();
        check("enable_cycle", cyc, e);
      end
    end
    if (bus.done_o === 1'b1) begin
      if (done_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done: got pulse expected none (cycle %0d)", cyc);
      end else begin
        d = done_q.pop_front();
        check("done_cycle", cyc, d.cyc);
        check("done_count", int'(cnt), int'(d.val));
        check("done_err", int'(bus.err_o), int'(d.err));
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Issue a start at a negedge; s is the cycle index of that negedge (CLEAR is s+1, RUN cycle 0 is s+2)
  task automatic start_run(input int p, input int t, input logic per, output int s);
    @(negedge clk);
    s              = cyc;
    bus.start_i    = 1'b1;
    bus.prescale_i = 8'(p);
    bus.target_i   = 4'(t);
    bus.periodic_i = per;
    @(negedge clk);
    bus.start_i    = 1'b0;
  endtask

  function automatic done_exp_t mk(input int c, input int v, input logic e);
    done_exp_t d;
    d.cyc = c;
    d.val = 4'(v);
    d.err = e;
    return d;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    n_cmp = 0;
    n_err = 0;
    inject = 1'b0;
    bus.start_i = 1'b0;
    bus.stop_i = 1'b0;
    bus.pause_i = 1'b0;
    bus.periodic_i = 1'b0;
    bus.prescale_i = 8'd0;
    bus.target_i = 4'd0;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_enable", int'(bus.counter_enable_o), 0);
    check("rst_cnt_rst_n", int'(bus.counter_rst_n_o), 0);
    check("rst_busy", int'(bus.busy_o), 0);
    check("rst_done", int'(bus.done_o), 0);
    check("rst_err", int'(bus.err_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_cnt_rst_n", int'(bus.counter_rst_n_o), 1);

    // One-shot prescale=2 target=3
    @(negedge clk);
    s = cyc + 1;
    en_q.push_back(s + 5); en_q.push_back(s + 8); en_q.push_back(s + 11);
    done_q.push_back(mk(s + 12, 3, 1'b0));
    start_run(2, 3, 1'b0, s);
    check("clear_rst_n_low", int'(bus.counter_rst_n_o), 0);
    check("clear_busy", int'(bus.busy_o), 1);
    @(negedge clk);
    check("run_rst_n_high", int'(bus.counter_rst_n_o), 1);
    wait_cyc(s + 12);
    check("oneshot_busy_after", int'(bus.busy_o), 0);
    repeat (3) @(negedge clk);

    // prescale=0 target=0: 16 back-to-back enables, wrap to 0
    @(negedge clk);
    s = cyc + 1;
    for (int k = 0; k < 16; k++) en_q.push_back(s + 3 + k);
    done_q.push_back(mk(s + 19, 0, 1'b0));
    start_run(0, 0, 1'b0, s);
    wait_cyc(s + 19);
    check("wrap_err", int'(bus.err_o), 0);
    repeat (3) @(negedge clk);

    // Periodic prescale=1 target=2, start ignored at restart, then stop
    @(negedge clk);
    s = cyc + 1;
    for (int r = 0; r < 3; r++) begin
      en_q.push_back(s + 4 + 6 * r);
      en_q.push_back(s + 6 + 6 * r);
      done_q.push_back(mk(s + 7 + 6 * r, 2, 1'b0));
    end
    start_run(1, 2, 1'b1, s);
    wait_cyc(s + 6);
    bus.start_i = 1'b1; bus.prescale_i = 8'd0; bus.target_i = 4'd1; bus.periodic_i = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_cyc(s + 8);
    check("periodic_cleared_count", int'(cnt), 0);
    wait_cyc(s + 21);
    bus.stop_i = 1'b1;
    @(negedge clk);
    bus.stop_i = 1'b0;
    check("stop_busy", int'(bus.busy_o), 0);
    check("stop_enable", int'(bus.counter_enable_o), 0);
    repeat (12) @(negedge clk);

    // Pause for 5 cycles, prescale=3 target=4
    @(negedge clk);
    s = cyc + 1;
    en_q.push_back(s + 6); en_q.push_back(s + 15); en_q.push_back(s + 19); en_q.push_back(s + 23);
    done_q.push_back(mk(s + 24, 4, 1'b0));
    start_run(3, 4, 1'b0, s);
    wait_cyc(s + 7);
    bus.pause_i = 1'b1;
    wait_cyc(s + 12);
    bus.pause_i = 1'b0;
    check("pause_busy", int'(bus.busy_o), 1);
    wait_cyc(s + 26);

    // Shadow mismatch sets sticky err_o
    @(negedge clk);
    s = cyc + 1;
    for (int k = 0; k < 4; k++) en_q.push_back(s + 3 + k);
    done_q.push_back(mk(s + 7, 4, 1'b1));
    start_run(0, 4, 1'b0, s);
    wait_cyc(s + 3);
    inject = 1'b1;
    check("err_before", int'(bus.err_o), 0);
    @(negedge clk);
    inject = 1'b0;
    check("err_rise", int'(bus.err_o), 1);
    wait_cyc(s + 10);
    check("err_sticky_idle", int'(bus.err_o), 1);

    // Next start clears err_o; async reset mid-run
    @(negedge clk);
    s = cyc + 1;
    en_q.push_back(s + 5);
    start_run(2, 3, 1'b0, s);
    check("err_cleared_by_start", int'(bus.err_o), 0);
    wait_cyc(s + 3);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    check("err_rise2", int'(bus.err_o), 1);
    wait_cyc(s + 6);
    rst_n = 1'b0;
    #1;
    check("async_rst_enable", int'(bus.counter_enable_o), 0);
    check("async_rst_cnt_rst_n", int'(bus.counter_rst_n_o), 0);
    check("async_rst_busy", int'(bus.busy_o), 0);
    check("async_rst_err", int'(bus.err_o), 0);
    repeat (3) @(negedge clk);
    check("held_rst_cnt_rst_n", int'(bus.counter_rst_n_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cnt_rst_n", int'(bus.counter_rst_n_o), 1);
    check("post_rst_busy", int'(bus.busy_o), 0);
    repeat (15) @(negedge clk);

    check("enable_queue_empty", en_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controller that sequences a 4-bit enable-gated counter board (counter with clock_i/enable_i/reset_n_i inputs, registered value output).
- Generates a prescaled enable pulse train and a synchronous clear for the counter, and counts a programmed number of ticks.
- Supports one-shot and periodic runs, with pause, and checks the counter's returned value against an internal shadow.
- Sits between the register/control logic and the counter instance; its outputs drive the counter's enable_i and reset_n_i.

Parameters:
CNT_W, 4, width of counter value and target
PRESC_W, 8, width of prescale divisor

Ports:
clock_i  in  1  system clock, rising edge
reset_n_i  in  1  asynchronous active-low reset
start_i  in  1  one-cycle start request; ignored unless IDLE
stop_i  in  1  one-cycle abort request
pause_i  in  1  level; freezes tick generation while high
periodic_i  in  1  sampled at start: 1 = periodic, 0 = one-shot
prescale_i  in  PRESC_W  sampled at start; enable period = prescale+1 cycles
target_i  in  CNT_W  sampled at start; ticks per run, 0 means 2^CNT_W
counter_value_i  in  CNT_W  value returned from counter
counter_enable_o  out  1  registered enable to counter
counter_rst_n_o  out  1  registered active-low clear to counter reset_n_i
busy_o  out  1  high in CLEAR or RUN
done_o  out  1  one-cycle pulse at run completion
err_o  out  1  sticky value-mismatch flag

Behaviour:
- Reset values: state=IDLE, counter_enable_o=0, counter_rst_n_o=0 (holds counter cleared during reset), busy_o=0, done_o=0, err_o=0. All outputs are registered.
- counter_rst_n_o rises on the first clock after reset deassertion.
- States: IDLE, CLEAR, RUN.
- IDLE: enable=0, rst_n=1, busy=0.
  - On start_i: latch prescale, target (0 becomes 2^CNT_W, so ticks counter is CNT_W+1 bits) and periodic.
  - Clear err_o and go to CLEAR.
- CLEAR: exactly one cycle. counter_rst_n_o=0 and enable=0.
  - Shadow value <= 0, ticks <= 0, prescale counter <= latched prescale.
  - Next state is RUN.
- RUN, prescaler:
  - When pause_i=0, the prescale counter decrements each cycle.
  - When it is 0 with pause_i=0 and ticks<target: assert counter_enable_o for the next cycle, reload the prescale counter, and increment ticks.
  - First pulse appears prescale+1 cycles after entering RUN. Pulse spacing is prescale+1 cycles; prescale=0 gives enable high every cycle.
- RUN, pause_i=1: freezes the prescale counter, forces enable=0 in the next cycle, and preserves ticks. Resume continues from the frozen count.
- RUN, completion: in the cycle after the final enable pulse (ticks==target, enable low), done_o=1 for one cycle.
  - One-shot: go to IDLE.
  - Periodic: go to CLEAR, then the run restarts with the latched settings.
- stop_i in CLEAR or RUN: go to IDLE next cycle; enable=0 from that cycle; no done_o.
  - stop_i has priority over completion and pause.
  - stop_i in IDLE is ignored.
- start_i outside IDLE is ignored, including in the same cycle as a periodic restart.
- Shadow check:
  - shadow <= shadow + counter_enable_o (mod 2^CNT_W) every cycle in RUN.
  - In RUN, counter_value_i != shadow sets err_o. err_o stays set until the next accepted start or reset.
  - No check is made in IDLE or CLEAR.
- Target 2^CNT_W: the counter wraps to 0 on the last tick; the shadow wraps identically, so no error is flagged.
- Async reset mid-run: all state returns to reset values immediately; no done_o.

Test Plan:
- Reset, then start with prescale=2, target=3, one-shot:
  - Required: counter_rst_n_o low for 1 cycle.
  - Enable pulses at RUN cycles 3, 6, 9.
  - done_o one cycle later; counter reads 3; back to IDLE with busy_o=0.
- prescale=0, target=0, one-shot: 16 consecutive enable cycles; counter wraps to 0; done_o once; err_o=0.
- Periodic, prescale=1, target=2: done_o every 6 cycles (2 pulses + CLEAR + completion cycle); counter clears to 0 between runs; stop_i ends it with no further done_o.
- pause_i held 5 cycles mid-run with prescale=3, target=4: no enables while paused; total run length extends by exactly 5 cycles.
- Force counter_value_i to shadow+1 during RUN: err_o rises next cycle and holds through done_o; the next start clears it.
- Assert reset_n_i low mid-RUN: outputs return to reset values asynchronously; counter_rst_n_o=0 until reset is released.
